// File: rtl/mio_bus_bridge_pkg.sv
// mio_bus_bridge_pkg: shared cpu bus types and constants (FSM states, IO region nibble, timeout read data)
package mio_bus_bridge_pkg;
   typedef enum logic [1:0] {IDLE, RAM_RD, IO_WAIT, DONE} state_t;
   localparam logic [3:0] IO_REGION = 4'hF;
   localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/mio_bus_bridge_addr_decode.sv
// mio_addr_decode: splits a cpu byte address into IO flag (addr[31:28]==IO_REGION) and RAM word address (addr[ADDR_W+1:2])
module mio_addr_decode
   import mio_bus_bridge_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic [31:0]       addr,
   output logic              is_io,
   output logic [ADDR_W-1:0] ram_addr
);
   logic unused_ok;
   assign is_io = addr[31:28] == IO_REGION;
   assign ram_addr = addr[ADDR_W+1:2];
   assign unused_ok = ^addr;
endmodule

// File: rtl/mio_bus_bridge.sv
// mio_bus_bridge: MEM-stage bridge (cpu_* in, cpu_rdata/stall/mio out) routing to zero-wait RAM (ram_*) or handshaked IO (io_*, bus_err); `define MIO_TIMEOUT_EN enables the IO wait timeout
module mio_bus_bridge
   import mio_bus_bridge_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              cpu_mio,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              io_req,
   output logic              io_we,
   output logic [31:0]       io_addr,
   output logic [31:0]       io_wdata,
   input  logic [31:0]       io_rdata,
   input  logic              io_ready,
   output logic              bus_err
);
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   state_t state_q, state_d;
   logic [31:0] rdata_q, rdata_d, cpu_rdata_q, cpu_rdata_d, addr_q, addr_d, wdata_q, wdata_d;
   logic we_q, we_d, is_io, timeout;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mio_addr_decode #(.ADDR_W(ADDR_W)) u_dec (
      .addr    (cpu_addr),
      .is_io   (is_io),
      .ram_addr(ram_addr)
   );
`ifdef MIO_TIMEOUT_EN
   assign timeout = cnt_q == CNT_W'(TIMEOUT);
`else
   assign timeout = 1'b0;
`endif
   assign io_addr = addr_q;
   assign io_wdata = wdata_q;
   assign ram_wdata = cpu_wdata;
   assign cpu_rdata_d = (state_q == DONE) ? rdata_q : cpu_rdata_q;
   assign cpu_rdata = cpu_rdata_d;
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      we_d = we_q;
      cnt_d = cnt_q;
      cpu_stall = 1'b0;
      cpu_mio = 1'b0;
      io_req = 1'b0;
      io_we = 1'b0;
      ram_we = 1'b0;
      bus_err = 1'b0;
      case (state_q)
         IDLE: if (cpu_req) begin
            ram_we = !is_io && cpu_we;
            cpu_stall = is_io || !cpu_we;
            state_d = is_io ? IO_WAIT : cpu_we ? IDLE : RAM_RD;
            if (is_io) begin
               addr_d = cpu_addr;
               we_d = cpu_we;
               wdata_d = cpu_wdata;
               cnt_d = '0;
            end
         end
         RAM_RD: begin
            cpu_stall = 1'b1;
            rdata_d = ram_rdata;
            state_d = DONE;
         end
         IO_WAIT: begin
            cpu_stall = 1'b1;
            cpu_mio = 1'b1;
            io_req = 1'b1;
            io_we = we_q;
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            if (io_ready) begin
               rdata_d = we_q ? rdata_q : io_rdata;
               state_d = DONE;
            end else if (timeout) begin
               bus_err = 1'b1;
               rdata_d = DEADBEEF;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rdata_q <= '0;
         cpu_rdata_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         we_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         we_q <= we_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: doc/mio_bus_bridge.md
MIO_BUS_BRIDGE -- requirements
Module: mio_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, data-RAM word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, IO wait-cycle limit.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have ports cpu_req in 1 (MEM-stage access valid), cpu_we in 1 (store), cpu_addr in 32, cpu_wdata in 32.
REQ-006 SHALL have ports cpu_rdata out 32 (load data), cpu_stall out 1 (freeze pipeline), cpu_mio out 1 (IO transfer active).
REQ-007 SHALL have ports ram_we out 1, ram_addr out ADDR_W (cpu_addr[ADDR_W+1:2]), ram_wdata out 32, ram_rdata in 32 (synchronous read, 1-cycle latency).
REQ-008 SHALL have ports io_req out 1, io_we out 1, io_addr out 32, io_wdata out 32, io_rdata in 32, io_ready in 1.
REQ-009 SHALL have port bus_err out 1, one-cycle IO timeout pulse.

Function
REQ-010 SHALL decode cpu_addr[31:28]==4'hF as IO, all else as RAM.
REQ-011 SHALL implement FSM states IDLE, RAM_RD, IO_WAIT, DONE.
REQ-012 IDLE, cpu_req, RAM, cpu_we: SHALL drive ram_we=1 combinationally that cycle, cpu_stall=0, stay IDLE (zero wait states).
REQ-013 IDLE, cpu_req, RAM, !cpu_we: SHALL assert cpu_stall, go RAM_RD; RAM_RD: cpu_stall=1, latch ram_rdata into rdata_q, go DONE.
REQ-014 IDLE, cpu_req, IO: SHALL assert cpu_stall, latch addr/we/wdata, go IO_WAIT.
REQ-015 IO_WAIT: SHALL drive io_req=1, cpu_mio=1, cpu_stall=1, io_* from latched values, increment wait counter.
REQ-016 IO_WAIT and io_ready: SHALL latch io_rdata into rdata_q (loads only), go DONE.
REQ-017 DONE: SHALL drive cpu_stall=0, cpu_rdata=rdata_q, ignore cpu_req, return IDLE.
REQ-018 Load latency: RAM 2 stall cycles, IO (wait cycles + 1) stall cycles.
REQ-019 io_ready outside IO_WAIT SHALL be ignored.
REQ-020 Wait counter SHALL be 8 bits minimum, cleared on entry to IO_WAIT, saturating, never wrapping.
REQ-021 cpu_rdata SHALL hold its last value outside DONE.

Reset
REQ-022 rst SHALL force IDLE from any state, including mid-transfer, at the next edge.
REQ-023 Reset values SHALL be: cpu_rdata=0, rdata_q=0, cpu_stall=0, cpu_mio=0, io_req=0, io_we=0, ram_we=0, bus_err=0, counter=0.

Configuration
REQ-024 With MIO_TIMEOUT_EN defined, counter==TIMEOUT in IO_WAIT without io_ready SHALL pulse bus_err, set rdata_q=32'hDEAD_BEEF, go DONE.
REQ-025 With MIO_TIMEOUT_EN defined, io_ready and timeout in the same cycle SHALL complete normally with no bus_err.
REQ-026 Without MIO_TIMEOUT_EN, IO_WAIT SHALL wait indefinitely, and bus_err SHALL be tied 0.

Structure
REQ-027 The shared cpu package SHALL hold the FSM state typedef, IO_REGION nibble 4'hF, and DEADBEEF constant.
REQ-028 Address decode SHALL be a sub-module mio_addr_decode (addr in, is_io/ram_addr out).

Verification
REQ-029 Store 0x1234_5678 to 0x0000_0010: ram_we=1 with ram_addr=4 that cycle, cpu_stall=0.
REQ-030 Load from 0x0000_0010 with ram_rdata=0x1234_5678: cpu_stall high 2 cycles, DONE shows cpu_rdata=0x1234_5678.
REQ-031 Load from 0xF000_0004, io_ready after 3 wait cycles with io_rdata=0xA5A5_0001: cpu_mio and io_req high during IO_WAIT, cpu_rdata=0xA5A5_0001 in DONE.
REQ-032 MIO_TIMEOUT_EN, TIMEOUT=4, io_ready held 0: bus_err pulses once after 4 wait cycles, cpu_rdata=0xDEAD_BEEF.
REQ-033 rst asserted 2 cycles into IO_WAIT: io_req, cpu_stall, cpu_mio all 0 next cycle, FSM in IDLE.
REQ-034 Stray io_ready=1 in IDLE with cpu_req=0: no state change, outputs unchanged.
